gshare_ckpt_predictor: RTL
==========================

// Module: gshare_ckpt_predictor
// PURPOSE
//  Parametrised gshare direction predictor with speculative global history and a checkpoint FIFO.
//  - Fetch gets a prediction in the same cycle. The prediction is shifted into the GHR speculatively.
//  - Each prediction's pre-shift history is checkpointed.
//  - Resolution is in order from the FIFO head. A mispredict restores the corrected history and
//    flushes all younger checkpoints. Sits between fetch and branch-resolve in the pipeline.
// PARAMETERS
//  HISTORY_LEN  8  GHR width = PHT index width; PHT has 2**HISTORY_LEN entries
//  COUNT_LEN    2  saturating counter width (>=2); prediction = counter MSB
//  PC_LSB       2  lowest PC bit used in the index; index uses pc[PC_LSB+HISTORY_LEN-1:PC_LSB]
//  CKPT_DEPTH   4  in-flight branch checkpoints (power of 2, >=2)
// PORTS
//  clk             in   1            clock
//  reset           in   1            synchronous, active-high
//  pc_bits_read    in   16           fetch PC
//  predict_valid   in   1            fetch requests a prediction
//  pred_ready      out  1            ~full; a request is accepted when predict_valid & pred_ready & ~mispredict
//  prediction      out  1            predicted direction (1 = taken), combinational
//  history_out     out  HISTORY_LEN  current speculative GHR
//  resolve_valid   in   1            oldest in-flight branch resolved this cycle
//  pc_bits_write   in   16           PC of the resolving branch
//  outcome         in   1            actual direction
//  mispredict      out  1            resolve_valid & ~empty & (outcome != head.pred), combinational
//  inflight_count  out  $clog2(CKPT_DEPTH)+1  checkpoints held
// BEHAVIOUR
//  - Reset:
//    - GHR = 0; FIFO empty; inflight_count = 0; pred_ready = 1; mispredict = 0.
//    - Every PHT counter = 2**(COUNT_LEN-1)-1 (weakly not-taken), so prediction = 0.
//    - Reset mid-operation discards all checkpoints the same edge.
//  - Predict (combinational): idx = GHR ^ pc_bits_read[PC_LSB+:HISTORY_LEN]; prediction = PHT[idx][COUNT_LEN-1].
//  - On an accepted request (edge):
//    - Push {GHR, prediction} to the FIFO tail.
//    - GHR <= {GHR[HISTORY_LEN-2:0], prediction}.
//  - Resolve (edge, when resolve_valid & ~empty):
//    - widx = head.hist ^ pc_bits_write[PC_LSB+:HISTORY_LEN].
//    - PHT[widx] is incremented if outcome=1, decremented if 0, saturating at 0 and 2**COUNT_LEN-1.
//    - Head is popped.
//  - Mispredict (edge):
//    - GHR <= {head.hist[HISTORY_LEN-2:0], outcome}.
//    - FIFO is fully emptied.
//    - A same-cycle predict request is dropped: not accepted, no push, no GHR shift.
//  - Correct resolve with a simultaneous accepted predict: pop and push both occur; count unchanged.
//  - Full: pred_ready = 0, even if a pop happens the same cycle (no bypass).
//  - Empty: resolve_valid is ignored. No PHT write, mispredict = 0, no state change.
//  - PHT read/write same index same cycle: the read returns the pre-update value (no bypass).
//  - FIFO pointers wrap modulo CKPT_DEPTH; full/empty are derived from the count, not pointer equality.
//  - Latency: prediction 0 cycles; PHT/GHR updates visible the cycle after the edge.
// CONFIGURATION
//  - GSHARE_STATS_EN defined:
//    - Adds outputs stat_branches[31:0] (resolves counted) and stat_mispredicts[31:0].
//    - Both counters saturate at 2**32-1 and clear on reset.
//  - Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - gshare_pkg:
//    - counter init/max helper functions.
//    - checkpoint entry layout {hist[HISTORY_LEN-1:0], pred}.
//    - counter-update function (saturating inc/dec).
//  - Sub-module branch_ckpt_fifo:
//    - Parametrised WIDTH/DEPTH sync FIFO with push, pop, flush, head data and count.
//    - Flush has priority over push.
//  - PHT is a reg array inside the top; its reset clears it via a generate loop.
// TESTING
//  - Reset, then pc=0x0040 -> prediction=0, history_out=0x00, inflight_count=0, pred_ready=1.
//  - Train pc=0x0040 taken x2 with GHR=0 (predict, then resolve outcome=1):
//    - First resolve -> mispredict=1; counter 1->2, GHR restored to 0x01.
//    - After re-aligning the GHR, the same index predicts 1.
//  - 4 predicts with no resolve (CKPT_DEPTH=4) -> pred_ready=0, inflight_count=4.
//    - A 5th predict_valid does not shift the GHR.
//    - Then a correct resolve plus a predict in the same cycle -> count stays 3 after pop (push blocked).
//  - 3 in flight with hist 0x00,0x00,0x01; resolve head outcome=1 against pred=0:
//    - mispredict=1; next cycle history_out=0x01, inflight_count=0.
//    - A same-cycle predict_valid is not pushed.
//  - Saturation: 5 taken resolves on one index -> counter=3, no wrap. 5 not-taken -> counter=0.
//  - resolve_valid while empty -> no PHT change, mispredict=0.
//    - With GSHARE_STATS_EN: stat_branches unchanged; the mispredict scenario increments stat_mispredicts by 1.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare checkpoint predictor: checkpoint entry
// layout and saturating-counter helpers.
package gshare_pkg;

    // Checkpoint entry is {hist[HISTORY_LEN-1:0], pred}
    localparam int unsigned CKPT_PRED_BIT = 0;
    localparam int unsigned CKPT_HIST_LSB = 1;

    function automatic int unsigned ckpt_width(input int unsigned hist_len);
        return hist_len + 32'd1;
    endfunction

    function automatic logic [31:0] ctr_init(input int unsigned count_len);
        return (32'd1 << (count_len - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_max(input int unsigned count_len);
        return (32'd1 << count_len) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_update(input logic [31:0] ctr,
                                              input logic        taken,
                                              input int unsigned count_len);
        logic [31:0] nxt;
        nxt = ctr;
        if (taken && (ctr != ctr_max(count_len))) begin
            nxt = ctr + 32'd1;
        end else if (!taken && (ctr != 32'd0)) begin
            nxt = ctr - 32'd1;
        end else begin
            nxt = ctr;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_ckpt_fifo.sv
// Synchronous checkpoint FIFO with push, pop and flush; flush wins over push.
// Full/empty come from the occupancy count so wrapped pointers are unambiguous.
module branch_ckpt_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/gshare_ckpt_predictor.sv
// gshare direction predictor with speculative GHR and in-order checkpoint recovery.
// Optional statistics outputs are enabled by defining GSHARE_STATS_EN.
module gshare_ckpt_predictor
    import gshare_pkg::*;
#(
    parameter int unsigned HISTORY_LEN = 8,
    parameter int unsigned COUNT_LEN   = 2,
    parameter int unsigned PC_LSB      = 2,
    parameter int unsigned CKPT_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   pc_bits_read,
    input  logic                          predict_valid,
    output logic                          pred_ready,
    output logic                          prediction,
    output logic [HISTORY_LEN-1:0]        history_out,
    input  logic                          resolve_valid,
    input  logic [15:0]                   pc_bits_write,
    input  logic                          outcome,
    output logic                          mispredict,
    output logic [$clog2(CKPT_DEPTH):0]   inflight_count
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]                   stat_branches,
    output logic [31:0]                   stat_mispredicts
`endif
);
    localparam int unsigned PHT_SIZE = 2 ** HISTORY_LEN;
    localparam int unsigned CKPT_W   = ckpt_width(HISTORY_LEN);
    localparam logic [COUNT_LEN-1:0] CTR_INIT = COUNT_LEN'(ctr_init(COUNT_LEN));

    logic [COUNT_LEN-1:0]   r_pht [PHT_SIZE];
    logic [HISTORY_LEN-1:0] r_ghr;

    logic [HISTORY_LEN-1:0] w_idx;
    logic [HISTORY_LEN-1:0] w_widx;
    logic [CKPT_W-1:0]      w_head;
    logic [CKPT_W-1:0]      w_push_data;
    logic [HISTORY_LEN-1:0] w_head_hist;
    logic                   w_head_pred;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_resolve;
    logic                   w_accept;
    logic [COUNT_LEN-1:0]   w_ctr_next;
    logic                   w_unused_pc;

    // Only the indexed PC slice participates in prediction
    assign w_unused_pc = ^{pc_bits_read, pc_bits_write};

    assign w_idx       = r_ghr ^ pc_bits_read[PC_LSB +: HISTORY_LEN];
    assign prediction  = r_pht[w_idx][COUNT_LEN-1];
    assign history_out = r_ghr;
    assign pred_ready  = ~w_full;

    assign w_head_hist = w_head[CKPT_HIST_LSB +: HISTORY_LEN];
    assign w_head_pred = w_head[CKPT_PRED_BIT];
    assign w_push_data = {r_ghr, prediction};

    assign w_resolve  = resolve_valid & ~w_empty;
    assign mispredict = w_resolve & (outcome != w_head_pred);
    assign w_accept   = predict_valid & pred_ready & ~mispredict;

    // Training index uses the history captured at prediction time, not the current GHR
    assign w_widx     = w_head_hist ^ pc_bits_write[PC_LSB +: HISTORY_LEN];
    assign w_ctr_next = COUNT_LEN'(ctr_update(32'(r_pht[w_widx]), outcome, COUNT_LEN));

    branch_ckpt_fifo #(
        .WIDTH (CKPT_W),
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_resolve),
        .i_flush (mispredict),
        .i_wdata (w_push_data),
        .o_head  (w_head),
        .o_count (inflight_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Speculative history: mispredict recovery takes precedence over a new shift
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= {HISTORY_LEN{1'b0}};
        end else if (mispredict) begin
            r_ghr <= {w_head_hist[HISTORY_LEN-2:0], outcome};
        end else if (w_accept) begin
            r_ghr <= {r_ghr[HISTORY_LEN-2:0], prediction};
        end else begin
            r_ghr <= r_ghr;
        end
    end

    for (genvar g = 0; g < PHT_SIZE; g++) begin : g_pht
        // One saturating counter per PHT entry
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pht[g] <= CTR_INIT;
            end else if (w_resolve && (w_widx == HISTORY_LEN'(g))) begin
                r_pht[g] <= w_ctr_next;
            end else begin
                r_pht[g] <= r_pht[g];
            end
        end
    end

`ifdef GSHARE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

    // Saturating resolve and mispredict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (w_resolve && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
